// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, relative branch and a return-address stack.
// Latency: every pc/depth/flag change is visible one cycle after the request is sampled.
// Backpressure: stall freezes pc, stack, depth and flags; stack overflow/underflow fall back to pc+1.
module pc_sequencer #(
    parameter int WIDTH       = 8,
    parameter int OFF_WIDTH   = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WIDTH-1:0]                   target,
    input  logic                               branch,
    input  logic [OFF_WIDTH-1:0]               offset,
    output logic [WIDTH-1:0]                   pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Return-address storage; left uninitialised, entries at or above depth are never read.
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic             push_en;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] off_ext;
    logic             is_full;
    logic             is_empty;

    assign pc_inc   = pc_q + WIDTH'(1);
    assign off_ext  = WIDTH'($signed(offset));
    assign push_idx = IW'(depth_q);
    assign top_idx  = IW'(depth_q - DW'(1));
    assign is_full  = (depth_q == DW'(STACK_DEPTH));
    assign is_empty = (depth_q == '0);

    // Next-state selection in priority order ret > call > jump > branch > increment; stall holds.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (!is_empty) begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - DW'(1);
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (call) begin
                if (!is_full) begin
                    push_en = 1'b1;
                    depth_d = depth_q + DW'(1);
                    pc_d    = target;
                end else begin
                    ovf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (jump) begin
                pc_d = target;
            end else if (branch) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Push the return address into the first free slot, reusing slots freed by earlier rets.
    always_ff @(posedge clk) begin
        if (!reset && push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer with a queue-based reference model.
// Stimulus pushes the expected post-edge state; a monitor pops and compares after each edge.
// Default parameters: WIDTH=8, OFF_WIDTH=8, STACK_DEPTH=4.
module tb_pc_sequencer;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset, stall, jump, call, ret, branch;
    logic [7:0] target, offset;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       stack_full, stack_empty, overflow, underflow;

    typedef struct {
        int pc;
        int depth;
        bit full;
        bit empty;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: pc as an integer, the stack as a plain queue.
    int m_pc = 0;
    int m_stk[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .jump       (jump),
        .call       (call),
        .ret        (ret),
        .target     (target),
        .branch     (branch),
        .offset     (offset),
        .pc         (pc),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected result.
    task automatic drive(input bit rst, input bit stl, input bit r, input bit c,
                         input bit j, input bit b, input int tgt, input int off);
        exp_t e;
        int   soff;
        reset  = rst;
        stall  = stl;
        ret    = r;
        call   = c;
        jump   = j;
        branch = b;
        target = tgt[7:0];
        offset = off[7:0];
        soff   = (off & 255) >= 128 ? (off & 255) - 256 : (off & 255);
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (stl) begin
            // state held
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_unf = 1'b1;
                m_pc  = (m_pc + 1) % 256;
            end
        end else if (c) begin
            if (m_stk.size() < SD) begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = tgt & 255;
            end else begin
                m_ovf = 1'b1;
                m_pc  = (m_pc + 1) % 256;
            end
        end else if (j) begin
            m_pc = tgt & 255;
        end else if (b) begin
            m_pc = ((m_pc + soff) % 256 + 256) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
        e.pc    = m_pc;
        e.depth = m_stk.size();
        e.full  = (m_stk.size() == SD);
        e.empty = (m_stk.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", int'(pc), e.pc);
                check("depth", int'(depth), e.depth);
                check("stack_full", int'(stack_full), int'(e.full));
                check("stack_empty", int'(stack_empty), int'(e.empty));
                check("overflow", int'(overflow), int'(e.ovf));
                check("underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    initial begin
        // Reset then 255 idle cycles to pc=255, then wrap to 0.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) idle();

        // Relative branches, negative and wrapping, and stall over branch.
        drive(0, 0, 0, 0, 1, 0, 8'h10, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 8'hFE);
        drive(0, 0, 0, 0, 1, 0, 8'hFF, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 8'h02);
        drive(0, 1, 0, 0, 0, 1, 0, 8'h05);
        drive(0, 0, 0, 0, 0, 1, 0, 8'h00);

        // Call / return, then call and jump together.
        drive(0, 0, 0, 0, 1, 0, 8'h20, 0);
        drive(0, 0, 0, 1, 0, 0, 8'h80, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 8'h44, 0);
        drive(0, 0, 1, 1, 1, 1, 8'h99, 8'h03);

        // Fill the stack, overflow, drain in reverse order, underflow.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 8'h30 + 16 * i, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 8'h55, 0);

        // Reset wins over a pending call with depth 3; a following ret underflows.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 8'hA0 + i, 0);
        drive(1, 0, 0, 1, 0, 0, 8'h77, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);

        // Randomised mix of overlapping requests.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        idle();
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning PC and address width in bits.
REQ-002 SHALL have parameter OFF_WIDTH, default 8, meaning signed branch-offset width in bits (OFF_WIDTH <= WIDTH).
REQ-003 SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address stack entries (>= 1).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold all state this cycle.
REQ-007 SHALL have port jump  input  1  absolute jump to target.
REQ-008 SHALL have port call  input  1  push return address and jump to target.
REQ-009 SHALL have port ret  input  1  pop return address into pc.
REQ-010 SHALL have port target  input  WIDTH  absolute address for jump/call.
REQ-011 SHALL have port branch  input  1  relative branch.
REQ-012 SHALL have port offset  input  OFF_WIDTH  two's-complement branch offset.
REQ-013 SHALL have port pc  output  WIDTH  current program counter (registered).
REQ-014 SHALL have port depth  output  clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-015 SHALL have port stack_full / stack_empty  output  1 each  depth==STACK_DEPTH / depth==0, combinational from depth.
REQ-016 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL evaluate one operation per cycle, priority: reset > stall > ret > call > jump > branch > increment.
REQ-018 SHALL, on stall, keep pc, stack contents, depth and flags unchanged.
REQ-019 SHALL, on increment, set pc <= pc + 1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-020 SHALL, on jump, set pc <= target.
REQ-021 SHALL, on branch, set pc <= pc + sign_extend(offset) modulo 2^WIDTH, relative to the current pc (offset 0 = self-loop).
REQ-022 SHALL, on call with depth < STACK_DEPTH, push (pc + 1) mod 2^WIDTH, increment depth, and set pc <= target.
REQ-023 SHALL, on call with depth == STACK_DEPTH, leave the stack and depth unchanged, set overflow, and increment pc.
REQ-024 SHALL, on ret with depth > 0, set pc <= top entry and decrement depth.
REQ-025 SHALL, on ret with depth == 0, set underflow and increment pc.
REQ-026 SHALL implement the stack as LIFO; a later call overwrites the slot freed by a previous ret.
REQ-027 SHALL give all pc changes one-cycle latency: the new value is visible on pc the cycle after the request is sampled.
REQ-028 SHALL keep overflow/underflow set until reset.

Reset
REQ-029 SHALL, on reset sampled high, set pc = 0, depth = 0, overflow = 0, underflow = 0, stack_empty = 1, stack_full = 0, regardless of any other input or operation in progress.
REQ-030 SHALL not require the stack storage contents to be cleared; they are unobservable while depth = 0.

Verification
REQ-031 Reset, then 255 idle cycles (WIDTH=8) -> pc = 255; next cycle pc = 0 (wrap).
REQ-032 pc=0x10, branch offset=0xFE -> pc=0x0E; pc=0xFF, branch offset=0x02 -> pc=0x01; stall asserted together with branch -> pc stays.
REQ-033 pc=0x20, call target=0x80 -> pc=0x80, depth=1; ret -> pc=0x21, depth=0; call and jump asserted together -> call taken.
REQ-034 STACK_DEPTH=4: five calls -> depth=4, stack_full=1, overflow=1, fifth call increments pc; four rets return the addresses in reverse order; fifth ret -> underflow=1, pc+1.
REQ-035 Reset asserted with depth=3 and call pending -> next cycle pc=0, depth=0, flags clear; a following ret sets underflow.
